// File: rtl/baud_rate_gen_frac.sv
// Fractional UART baud generator: oversample tick (o_rate) and bit tick, both registered one cycle after cnt==0.
// No backpressure; i_enable stalls all counting, i_sync_clear realigns the phase.
module baud_rate_gen_frac #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_BAUD = 19200,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_sync_clear,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_div_pending,
    output logic              o_div_err,
    output logic              o_rate,
    output logic              o_bit_tick
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    // Rounded default divisor in units of 1/2^FRAC_W clock
    localparam logic [63:0] DEN     = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
    localparam logic [63:0] DEF_DIV = (64'(CLK_FREQ) * (64'd1 << FRAC_W) * 64'd2 + DEN) / (64'd2 * DEN);
    localparam logic [DIV_W-1:0]  DEF_I_RAW = DIV_W'(DEF_DIV >> FRAC_W);
    localparam logic [DIV_W-1:0]  DEF_I     = (DEF_I_RAW < DIV_W'(2)) ? DIV_W'(2) : DEF_I_RAW;
    localparam logic [FRAC_W-1:0] DEF_F     = FRAC_W'(DEF_DIV);

    logic [DIV_W-1:0]  r_div_i;
    logic [FRAC_W-1:0] r_div_f;
    logic [DIV_W-1:0]  r_shd_i;
    logic [FRAC_W-1:0] r_shd_f;
    logic              r_pending;
    logic              r_err;
    logic [DIV_W:0]    r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [OS_W-1:0]   r_os_cnt;
    logic              r_rate;
    logic              r_bit_tick;

    logic [DIV_W-1:0]  w_use_i;
    logic [FRAC_W-1:0] w_use_f;
    logic [FRAC_W:0]   w_sum;
    logic              w_carry;
    logic [DIV_W:0]    w_reload_cnt;
    logic [DIV_W:0]    w_clear_cnt;
    logic              w_cnt_zero;
    logic              w_reload;
    logic              w_apply;
    logic              w_load_bad;
    logic [DIV_W-1:0]  w_load_i;

    // A pending shadow takes effect on the very reload/clear that applies it
    assign w_use_i      = r_pending ? r_shd_i : r_div_i;
    assign w_use_f      = r_pending ? r_shd_f : r_div_f;
    assign w_sum        = {1'b0, r_acc} + {1'b0, w_use_f};
    assign w_carry      = w_sum[FRAC_W];
    assign w_reload_cnt = {1'b0, w_use_i} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, w_carry};
    assign w_clear_cnt  = {1'b0, w_use_i} - (DIV_W+1)'(1);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_reload     = i_enable && w_cnt_zero && !i_sync_clear;
    assign w_apply      = i_sync_clear || w_reload;
    assign w_load_bad   = (i_div_int < DIV_W'(2));
    assign w_load_i     = w_load_bad ? DIV_W'(2) : i_div_int;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_div_i    <= DEF_I;
            r_div_f    <= DEF_F;
            r_shd_i    <= DEF_I;
            r_shd_f    <= DEF_F;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= {1'b0, DEF_I} - (DIV_W+1)'(1);
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_rate     <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            r_rate     <= 1'b0;
            r_bit_tick <= 1'b0;

            if (w_apply && r_pending) begin
                r_div_i   <= r_shd_i;
                r_div_f   <= r_shd_f;
                r_pending <= 1'b0;
            end

            // A load coinciding with an apply re-arms pending for the next reload
            if (i_div_load) begin
                r_shd_i   <= w_load_i;
                r_shd_f   <= i_div_frac;
                r_pending <= 1'b1;
                if (w_load_bad) begin
                    r_err <= 1'b1;
                end
            end

            if (i_sync_clear) begin
                r_cnt    <= w_clear_cnt;
                r_acc    <= '0;
                r_os_cnt <= '0;
            end else if (i_enable) begin
                if (w_cnt_zero) begin
                    r_cnt  <= w_reload_cnt;
                    r_acc  <= w_sum[FRAC_W-1:0];
                    r_rate <= 1'b1;
                    if (r_os_cnt == OS_LAST) begin
                        r_os_cnt   <= '0;
                        r_bit_tick <= 1'b1;
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt - (DIV_W+1)'(1);
                end
            end
        end
    end

    assign o_div_pending = r_pending;
    assign o_div_err     = r_err;
    assign o_rate        = r_rate;
    assign o_bit_tick    = r_bit_tick;

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Directed bench for baud_rate_gen_frac at 16 kHz / 1000 baud / x4 oversample (default divisor 4.0).
module tb_baud_rate_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sclr;
    logic        ld;
    logic [15:0] di;
    logic [3:0]  df;
    logic        pend;
    logic        err;
    logic        rate;
    logic        bt;

    int n_chk      = 0;
    int n_fail     = 0;
    int pulse_no   = 0;
    int orphan_bt  = 0;

    always #5 clk = ~clk;

    baud_rate_gen_frac #(
        .CLK_FREQ    (16000),
        .DEFAULT_BAUD(1000),
        .OVERSAMPLE  (4),
        .DIV_W       (16),
        .FRAC_W      (4)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_sync_clear (sclr),
        .i_div_int    (di),
        .i_div_frac   (df),
        .i_div_load   (ld),
        .o_div_pending(pend),
        .o_div_err    (err),
        .o_rate       (rate),
        .o_bit_tick   (bt)
    );

    always @(negedge clk) begin
        if (bt && !rate) orphan_bt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next rate pulse (bounded); also checks bit_tick phase
    task automatic wait_rate(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            n++;
            if (rate) break;
        end
        if (rate) begin
            pulse_no++;
            check({tag, "_bt"}, 32'(bt), 32'(pulse_no % 4 == 0));
        end
    endtask

    task automatic expect_gap(input string tag, input int exp);
        int n;
        wait_rate(tag, n);
        check(tag, n, exp);
    endtask

    task automatic load_div(input logic [15:0] i, input logic [3:0] f);
        di = i;
        df = f;
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    initial begin
        int n;
        int sum;
        int iv[2];
        int stall_ticks;

        rst = 1'b1; en = 1'b0; sclr = 1'b0; ld = 1'b0; di = '0; df = '0;
        step();
        step();
        check("rst_rate", 32'(rate), 0);
        check("rst_bt",   32'(bt),   0);
        check("rst_pend", 32'(pend), 0);
        check("rst_err",  32'(err),  0);

        // 1: default divisor 4, bit_tick every 4th rate pulse
        rst = 1'b0; en = 1'b1;
        expect_gap("t1_first", 4);
        for (int k = 0; k < 7; k++) expect_gap("t1_gap", 4);

        // 2: I=3 F=8 -> 3,4 alternating after the current period
        load_div(16'd3, 4'd8);
        check("t2_pend", 32'(pend), 1);
        expect_gap("t2_cur", 3);
        check("t2_pend_clr", 32'(pend), 0);
        sum = 0;
        for (int k = 0; k < 32; k++) begin
            wait_rate("t2", n);
            if (k < 2) iv[k] = n;
            sum += n;
        end
        check("t2_iv0", iv[0], 3);
        check("t2_iv1", iv[1], 4);
        check("t2_span", sum, 112);

        // back to 4.0; acc=8 with cnt=2 after the 32nd pulse
        load_div(16'd4, 4'd0);
        expect_gap("t3_prep", 2);
        expect_gap("t3_base", 4);

        // 3: load I=6 one cycle into a 4-cycle period
        load_div(16'd6, 4'd0);
        check("t3_pend", 32'(pend), 1);
        expect_gap("t3_cur", 3);
        check("t3_pend_clr", 32'(pend), 0);
        expect_gap("t3_new", 6);
        expect_gap("t3_new2", 6);

        // 4: illegal I=1 clamps to 2, sticky error until reset
        load_div(16'd1, 4'd0);
        check("t4_err", 32'(err), 1);
        expect_gap("t4_cur", 5);
        for (int k = 0; k < 3; k++) expect_gap("t4_clamp", 2);
        check("t4_err_sticky", 32'(err), 1);
        rst = 1'b1;
        step();
        step();
        check("t4_rst_err",  32'(err),  0);
        check("t4_rst_rate", 32'(rate), 0);
        check("t4_rst_pend", 32'(pend), 0);
        rst = 1'b0;
        pulse_no = 0;
        expect_gap("t4_rst_first", 4);
        expect_gap("t4_rst_gap", 4);

        // 5a: 5-cycle stall one cycle into the period
        step();
        en = 1'b0;
        stall_ticks = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (rate || bt) stall_ticks++;
        end
        check("t5_stall_ticks", stall_ticks, 0);
        en = 1'b1;
        wait_rate("t5_stall", n);
        check("t5_stretch", 1 + 5 + n, 9);

        // 5b: sync_clear two cycles into the period
        step();
        step();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        check("t5_clr_rate", 32'(rate), 0);
        pulse_no = 0;
        expect_gap("t5_clr_first", 4);
        for (int k = 0; k < 3; k++) expect_gap("t5_clr_gap", 4);

        // 6: reset mid-period discards a pending load
        load_div(16'd6, 4'd0);
        check("t6_pend", 32'(pend), 1);
        step();
        rst = 1'b1;
        step();
        check("t6_rate", 32'(rate), 0);
        check("t6_bt",   32'(bt),   0);
        check("t6_pend_clr", 32'(pend), 0);
        check("t6_err",  32'(err),  0);
        rst = 1'b0;
        pulse_no = 0;
        expect_gap("t6_first", 4);
        expect_gap("t6_gap", 4);
        check("t6_pend_after", 32'(pend), 0);

        check("orphan_bit_tick", orphan_bt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
